fsk_bit_detector: RTL and testbench
===================================

Name: fsk_bit_detector

Overview:
Integrate-and-dump bit decision stage directly downstream of the FSK demodulator channel splitter. Consumes the two per-tone sample streams (q1 = space channel, s=0; q2 = mark channel, s=1). Counts high samples on each channel over one symbol window of SAMPLES_PER_BIT clocks and issues one decided bit per window with a valid strobe and an erasure flag. Output feeds the receive deframer.

Parameters:
SAMPLES_PER_BIT, 16, clocks per symbol window; legal range 2..1024.
MIN_COUNT, 4, minimum winning-channel count for a trusted decision; legal range 1..SAMPLES_PER_BIT.
CNT_W, $clog2(SAMPLES_PER_BIT+1), derived local width of the channel and sample counters; not overridable.

Ports:
clk  input  1  rising-edge clock, same domain as the demodulator
rst_n  input  1  synchronous active-low reset
en  input  1  detector enable; low aborts the current window
align  input  1  symbol-timing pulse; restarts the window at this sample
q1_in  input  1  space-channel sample (demodulator q1)
q2_in  input  1  mark-channel sample (demodulator q2)
bit_out  output  1  decided bit (1 = mark, 0 = space)
bit_valid  output  1  one-cycle strobe; bit_out/erasure valid while high
erasure  output  1  decision untrusted (tie or weak signal)

Behaviour:
- All state changes occur on the rising edge of clk. Reset is synchronous and active-low: with rst_n=0 at the edge, the block clears sample_idx, cnt1, cnt2, bit_out, bit_valid, erasure and last_bit to 0. The state machine goes to IDLE.
- States:
  - IDLE: entered on reset or when en=0. Counters are held at 0. Leave IDLE for INTEGRATE on the first edge with en=1; that edge's sample is sample 0.
  - INTEGRATE: on each edge with en=1, cnt1 += q1_in and cnt2 += q2_in, and sample_idx increments.
- Window end: the edge with sample_idx = SAMPLES_PER_BIT-1 captures the final sample and computes the decision combinationally from the final totals c1/c2 (counts including this sample). At the same edge:
  - register bit_valid=1, bit_out and erasure;
  - reset cnt1, cnt2 and sample_idx to 0.
  - The next edge is sample 0 of the next window. There are no gap cycles; throughput is one bit per SAMPLES_PER_BIT clocks.
- Latency: bit_valid is high during the clock cycle that follows the edge capturing the last sample. It is high for exactly one cycle, and is 0 at all other times.
- Decision rule:
  - c2 > c1: bit_out=1.
  - c1 > c2: bit_out=0.
  - c1 == c2: bit_out=last_bit and erasure=1.
  - Also erasure=1 when max(c1,c2) < MIN_COUNT; bit_out still follows the compare.
  - last_bit is updated to bit_out on every valid strobe.
- q1_in=q2_in=1 in the same cycle (not produced by the demodulator) increments both counters. This is not an error.
- Counter widths: CNT_W bits. Counts cannot exceed SAMPLES_PER_BIT, so no saturation logic.
- align=1 with en=1: discard partial counts. This edge's sample becomes sample 0, so cnt = q_in and sample_idx = 1. No strobe is issued for the aborted window.
  - If align coincides with the window-end edge, the completed window is still reported (strobe issued) and the align sample starts the new window; the new window does not include the previous sample.
  - align with en=0 is ignored.
- en=0 mid-window: abort to IDLE at that edge with counters cleared and no strobe. bit_out and erasure hold their last values. An en=0 edge never produces a strobe.
- rst_n=0 mid-window: cleared as above; any pending decision is lost.
- bit_out and erasure change only on strobe edges or reset.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with random q1_in/q2_in and en=1 -> bit_out=0, bit_valid=0 and erasure=0 throughout. The first strobe comes 16 edges after release.
- Clean bits (SPB=16, MIN_COUNT=4): 16 samples q2_in=1/q1_in=0, then 16 samples q1_in=1/q2_in=0 -> strobes 16 cycles apart with bit_out=1 then 0, erasure=0, and no gap cycles.
- Tie: 8 samples q1_in=1 and 8 samples q2_in=1 after a decided 1 -> bit_out=1, erasure=1. Weak signal: 3 q2_in highs and 0 q1_in highs -> bit_out=1, erasure=1.
- Align: pulse align at sample 5 of a window -> no strobe for the partial window. The next strobe comes 16 edges after the align edge, and its counts include the align-cycle sample.
- Align on the window-end edge -> strobe for the completed window, and the next strobe follows exactly 16 edges later.
- Enable drop: en=0 at sample 10 for 4 cycles, then en=1 -> no strobe and bit_out held. The next strobe comes 16 edges after en returns; apply rst_n=0 at sample 7 and check no strobe and counts cleared.

Source files
------------

// File: rtl/fsk_bit_detector_if.sv
// fsk_bit_detector_if: per-tone sample inputs and decided-bit outputs of the FSK bit detector
interface fsk_bit_detector_if;
  logic en;
  logic align;
  logic q1_in;
  logic q2_in;
  logic bit_out;
  logic bit_valid;
  logic erasure;
  modport master (output en, align, q1_in, q2_in, input bit_out, bit_valid, erasure);
  modport slave (input en, align, q1_in, q2_in, output bit_out, bit_valid, erasure);
endinterface

// File: rtl/fsk_bit_detector.sv
// fsk_bit_detector: integrate-and-dump decision over one symbol window of space/mark samples
module fsk_bit_detector #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int MIN_COUNT = 4
) (
  input logic clk,
  input logic rst_n,
  fsk_bit_detector_if.slave bus
);
  localparam int CNT_W = $clog2(SAMPLES_PER_BIT + 1);
  typedef enum logic {IDLE, INTEGRATE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] sample_idx_q, sample_idx_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, erasure_q, erasure_d;
  logic [CNT_W-1:0] c1, c2, hi;
  logic restart, last, win_end;
  always_comb begin
    c1 = cnt1_q + CNT_W'(bus.q1_in);
    c2 = cnt2_q + CNT_W'(bus.q2_in);
    hi = c1 > c2 ? c1 : c2;
    restart = state_q == IDLE || bus.align;
    last = state_q == INTEGRATE && sample_idx_q == CNT_W'(SAMPLES_PER_BIT - 1);
    win_end = bus.en && last;
    // bit_out_q doubles as the last decided bit used to break ties
    bit_out_d = !win_end ? bit_out_q : c2 > c1 ? 1'b1 : c1 > c2 ? 1'b0 : bit_out_q;
    erasure_d = win_end ? (c1 == c2 || hi < CNT_W'(MIN_COUNT)) : erasure_q;
    bit_valid_d = win_end;
    cnt1_d = !bus.en ? '0 : restart ? CNT_W'(bus.q1_in) : last ? '0 : c1;
    cnt2_d = !bus.en ? '0 : restart ? CNT_W'(bus.q2_in) : last ? '0 : c2;
    sample_idx_d = !bus.en ? '0 : restart ? CNT_W'(1) : last ? '0 : sample_idx_q + CNT_W'(1);
    state_d = bus.en ? INTEGRATE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sample_idx_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
      bit_out_q <= 1'b0;
      bit_valid_q <= 1'b0;
      erasure_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sample_idx_q <= sample_idx_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      bit_out_q <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      erasure_q <= erasure_d;
    end
  end
  assign bus.bit_out = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.erasure = erasure_q;
endmodule

// File: tb/tb_fsk_bit_detector.sv
// tb_fsk_bit_detector: directed and randomized checks against a window-queue reference model
module tb_fsk_bit_detector;
  localparam int SPB = 16;
  localparam int MINC = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fsk_bit_detector_if bus ();
  fsk_bit_detector #(.SAMPLES_PER_BIT(SPB), .MIN_COUNT(MINC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  logic [1:0] win[$];
  logic ev = 1'b0, eb = 1'b0, ee = 1'b0, last_bit = 1'b0;
  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic decide();
    int c1 = 0, c2 = 0;
    foreach (win[i]) begin
      c1 += int'(win[i][1]);
      c2 += int'(win[i][0]);
    end
    ev = 1'b1;
    eb = c2 > c1 ? 1'b1 : c1 > c2 ? 1'b0 : last_bit;
    ee = (c1 == c2) || ((c1 > c2 ? c1 : c2) < MINC);
    last_bit = eb;
  endtask
  task automatic model();
    logic [1:0] s = {bus.q1_in, bus.q2_in};
    ev = 1'b0;
    if (!rst_n) begin
      win.delete();
      eb = 1'b0;
      ee = 1'b0;
      last_bit = 1'b0;
    end else if (!bus.en) win.delete();
    else if (bus.align) begin
      if (win.size() == SPB - 1) begin
        win.push_back(s);
        decide();
      end
      win.delete();
      win.push_back(s);
    end else begin
      win.push_back(s);
      if (win.size() == SPB) begin
        decide();
        win.delete();
      end
    end
  endtask
  task automatic step(input logic r, input logic e, input logic a, input logic q1, input logic q2);
    rst_n = r;
    bus.en = e;
    bus.align = a;
    bus.q1_in = q1;
    bus.q2_in = q2;
    @(posedge clk);
    model();
    #1;
    chk("valid", {2'b0, bus.bit_valid}, {2'b0, ev});
    chk("bit", {2'b0, bus.bit_out}, {2'b0, eb});
    chk("erasure", {2'b0, bus.erasure}, {2'b0, ee});
  endtask
  task automatic feed(input int n, input logic q1, input logic q2);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, q1, q2);
  endtask
  function automatic logic [2:0] outs();
    return {bus.bit_valid, bus.bit_out, bus.erasure};
  endfunction
  initial begin
    int p1 = 30, p2 = 30;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'($urandom), 1'($urandom));
      chk("reset_outs", outs(), 3'b000);
    end
    feed(15, 1'b0, 1'b1);
    chk("first_no_early", outs(), 3'b000);
    feed(1, 1'b0, 1'b1);
    chk("clean_mark", outs(), 3'b110);
    feed(15, 1'b1, 1'b0);
    chk("clean_hold", outs(), 3'b010);
    feed(1, 1'b1, 1'b0);
    chk("clean_space", outs(), 3'b100);
    feed(16, 1'b0, 1'b1);
    chk("pre_tie", outs(), 3'b110);
    feed(8, 1'b1, 1'b0);
    feed(8, 1'b0, 1'b1);
    chk("tie", outs(), 3'b111);
    feed(3, 1'b0, 1'b1);
    feed(13, 1'b0, 1'b0);
    chk("weak", outs(), 3'b111);
    feed(5, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    feed(14, 1'b0, 1'b1);
    chk("align_mid_nostrobe", outs(), 3'b011);
    feed(1, 1'b0, 1'b1);
    chk("align_mid_strobe", outs(), 3'b110);
    feed(15, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("align_end_strobe", outs(), 3'b100);
    feed(14, 1'b0, 1'b1);
    chk("align_end_wait", outs(), 3'b000);
    feed(1, 1'b0, 1'b1);
    chk("align_end_next", outs(), 3'b110);
    feed(10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("en_drop_hold", outs(), 3'b010);
    feed(15, 1'b1, 1'b0);
    chk("en_return_wait", outs(), 3'b010);
    feed(1, 1'b1, 1'b0);
    chk("en_return_strobe", outs(), 3'b100);
    feed(7, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_mid", outs(), 3'b000);
    feed(6, 1'b0, 1'b1);
    feed(10, 1'b1, 1'b0);
    chk("rst_counts_cleared", outs(), 3'b100);
    for (int i = 0; i < 4000; i++) begin
      if (i % SPB == 0) begin
        p1 = $urandom_range(0, 60);
        p2 = $urandom_range(0, 60);
      end
      step($urandom_range(0, 299) != 0, $urandom_range(0, 24) != 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < p1, $urandom_range(0, 99) < p2);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
